// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// UART transmitter: accepts a byte over valid/ready and shifts it out LSB
// first as start bit, data bits, optional even parity bit and stop bit.
// Every bit lasts CLOCKS_PER_BIT clocks. State codes line up with the Rx
// path so loopback benches can compare the two state vectors directly.
// The tx_state width covers code INPUT_DATA_WIDTH+3 only when
// INPUT_DATA_WIDTH+3 is not a power of two (true for the default of 8).
module uart_tx_serializer #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int PARITY_ENABLED   = 1,
    parameter int CLOCKS_PER_BIT   = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [INPUT_DATA_WIDTH-1:0]           tx_data,
    input  logic                                  tx_valid,
    output logic                                  tx_ready,
    output logic                                  serial_out,
    output logic                                  tx_busy,
    output logic                                  tx_done,
    output logic [$clog2(INPUT_DATA_WIDTH+3)-1:0] tx_state
);

    localparam int SW = $clog2(INPUT_DATA_WIDTH + 3);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int IW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

    localparam logic [SW-1:0] TX_IDLE          = SW'(0);
    localparam logic [SW-1:0] TX_START_BIT     = SW'(1);
    localparam logic [SW-1:0] TX_DATA_BIT_0    = SW'(2);
    localparam logic [SW-1:0] TX_DATA_BIT_LAST = SW'(INPUT_DATA_WIDTH + 1);
    localparam logic [SW-1:0] TX_PARITY_BIT    = SW'(INPUT_DATA_WIDTH + 2);
    localparam logic [SW-1:0] TX_STOP_BIT      = SW'(INPUT_DATA_WIDTH + 3);

    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_BIT - 1);

    // Declaration initialisers give the reset values at power-up as well.
    logic [SW-1:0]               r_state      = TX_IDLE;
    logic [CW-1:0]               r_cnt        = '0;
    logic [INPUT_DATA_WIDTH-1:0] r_shift      = '0;
    logic                        r_parity     = 1'b0;
    logic                        r_serial_out = 1'b1;
    logic                        r_done       = 1'b0;

    logic [SW-1:0] w_state_next;
    logic          w_serial_next;
    logic          w_done_next;
    logic          w_accept;
    logic          w_cnt_last;
    logic          w_illegal;
    logic [IW-1:0] w_bit_idx;

    assign tx_ready   = (r_state == TX_IDLE);
    assign tx_busy    = !tx_ready;
    assign tx_done    = r_done;
    assign serial_out = r_serial_out;
    assign tx_state   = r_state;

    assign w_accept   = tx_valid && tx_ready;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_illegal  = (r_state > TX_STOP_BIT);

    // State register; reset wins over a simultaneous tx_valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values; blocking here would create order races.
        if (!reset) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: idle waits for a handshake, others advance on terminal count.
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_next unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        if (r_state == TX_IDLE) begin
            if (tx_valid) begin
                w_state_next = TX_START_BIT;
            end
        end else if (w_illegal) begin
            w_state_next = TX_IDLE;
        end else if (w_cnt_last) begin
            if (r_state == TX_STOP_BIT) begin
                w_state_next = TX_IDLE;
            end else if (r_state == TX_DATA_BIT_LAST) begin
                w_state_next = (PARITY_ENABLED != 0) ? TX_PARITY_BIT : TX_STOP_BIT;
            end else begin
                w_state_next = r_state + SW'(1);
            end
        end
    end

    // Output decode from the next state so the registered line moves with the state.
    always_comb begin
        w_bit_idx     = IW'(w_state_next - TX_DATA_BIT_0);
        w_serial_next = 1'b1;
        w_done_next   = (r_state == TX_STOP_BIT) && w_cnt_last;
        if (w_state_next == TX_START_BIT) begin
            w_serial_next = 1'b0;
        end else if ((w_state_next >= TX_DATA_BIT_0) && (w_state_next <= TX_DATA_BIT_LAST)) begin
            w_serial_next = r_shift[w_bit_idx];
        end else if (w_state_next == TX_PARITY_BIT) begin
            w_serial_next = r_parity;
        end
    end

    // Bit-timing counter, byte/parity capture on accept, registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_serial_out <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            r_serial_out <= w_serial_next;
            r_done       <= w_done_next;
            if ((r_state == TX_IDLE) || w_illegal || w_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_shift  <= tx_data;
                r_parity <= ^tx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Directed bench: one instance with even parity, one without, both at
// CLOCKS_PER_BIT=4. Outputs are sampled on the falling edge; sel picks
// which instance is being driven and observed.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       sel;

    logic       w_valid0, w_valid1;
    logic       w_ready0, w_ready1, w_ser0, w_ser1;
    logic       w_busy0, w_busy1, w_done0, w_done1;
    logic [3:0] w_st0, w_st1;

    logic       ready, ser, busy, done;
    logic [3:0] st;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign w_valid0 = tx_valid & ~sel;
    assign w_valid1 = tx_valid & sel;
    assign ready    = sel ? w_ready1 : w_ready0;
    assign ser      = sel ? w_ser1   : w_ser0;
    assign busy     = sel ? w_busy1  : w_busy0;
    assign done     = sel ? w_done1  : w_done0;
    assign st       = sel ? w_st1    : w_st0;

    uart_tx_serializer #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .CLOCKS_PER_BIT(CPB)) u_dut_par (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(w_valid0),
        .tx_ready(w_ready0), .serial_out(w_ser0), .tx_busy(w_busy0),
        .tx_done(w_done0), .tx_state(w_st0)
    );

    uart_tx_serializer #(.INPUT_DATA_WIDTH(8), .PARITY_ENABLED(0), .CLOCKS_PER_BIT(CPB)) u_dut_nopar (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(w_valid1),
        .tx_ready(w_ready1), .serial_out(w_ser1), .tx_busy(w_busy1),
        .tx_done(w_done1), .tx_state(w_st1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is at a falling edge with tx_data/tx_valid already driven.
    // Runs one frame from the accept edge through the tx_done cycle.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic exp_par,
                             input bit iso, input bit b2b, input logic [7:0] nxt);
        bit          par_en;
        int          nbits, slot, glitch, bad_st, ready_bad, done_hi;
        logic [10:0] exp_bits, got_bits;
        logic [3:0]  exp_st;
        par_en    = !sel;
        nbits     = par_en ? 11 : 10;
        exp_bits  = '0;
        exp_bits[8:1] = d;
        if (par_en) begin
            exp_bits[9]  = exp_par;
            exp_bits[10] = 1'b1;
        end else begin
            exp_bits[9]  = 1'b1;
        end
        got_bits  = '0;
        glitch    = 0;
        bad_st    = 0;
        ready_bad = 0;
        done_hi   = 0;
        @(posedge clk);
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge clk);
            slot = c / CPB;
            if (slot == 0)                    exp_st = 4'd1;
            else if (slot <= 8)               exp_st = 4'(slot + 1);
            else if (par_en && slot == 9)     exp_st = 4'd10;
            else                              exp_st = 4'd11;
            if ((c % CPB) == (CPB / 2)) got_bits[slot] = ser;
            if (ser !== exp_bits[slot]) glitch++;
            if (st !== exp_st) bad_st++;
            if (ready !== 1'b0 || busy !== 1'b1) ready_bad++;
            if (done !== 1'b0) done_hi++;
            if (!b2b && c == 0) tx_valid = 1'b0;
            if (iso && c == 2 * CPB + 1) begin
                tx_data  = ~d;
                tx_valid = 1'b1;
            end
            if (iso && !b2b && c == 2 * CPB + 2) tx_valid = 1'b0;
        end
        check({tag, " bits"},     32'(got_bits), 32'(exp_bits));
        check({tag, " timing"},   glitch, 0);
        check({tag, " states"},   bad_st, 0);
        check({tag, " busy"},     ready_bad, 0);
        check({tag, " early_done"}, done_hi, 0);
        @(negedge clk);
        check({tag, " done"},     done, 1);
        check({tag, " done_rdy"}, ready, 1);
        check({tag, " done_ser"}, ser, 1);
        check({tag, " done_st"},  st, 0);
        if (b2b) begin
            tx_data = nxt;
        end else begin
            @(negedge clk);
            check({tag, " done_pulse"}, done, 0);
            check({tag, " idle_rdy"},   ready, 1);
            check({tag, " idle_st"},    st, 0);
        end
    endtask

    initial begin
        int done_cnt;
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        sel      = 1'b0;

        // Reset held with tx_valid high: outputs stay idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst ser",   ser, 1);
            check("rst ready", ready, 1);
            check("rst busy",  busy, 0);
            check("rst done",  done, 0);
            check("rst state", st, 0);
        end
        tx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("post_rst state", st, 0);
        check("post_rst ser",   ser, 1);

        // Parity-enabled frames; parity bits computed by hand.
        tx_data = 8'hA5; tx_valid = 1'b1;
        run_frame("p_a5", 8'hA5, 1'b0, 0, 0, 8'h00);
        tx_data = 8'h01; tx_valid = 1'b1;
        run_frame("p_01", 8'h01, 1'b1, 0, 0, 8'h00);
        tx_data = 8'hFF; tx_valid = 1'b1;
        run_frame("p_ff", 8'hFF, 1'b0, 0, 0, 8'h00);

        // Parity-disabled instance: 40-cycle frames.
        sel = 1'b1;
        tx_data = 8'hA5; tx_valid = 1'b1;
        run_frame("np_a5", 8'hA5, 1'b0, 0, 0, 8'h00);
        tx_data = 8'h01; tx_valid = 1'b1;
        run_frame("np_01", 8'h01, 1'b0, 0, 0, 8'h00);
        sel = 1'b0;

        // Back-to-back with tx_valid held: second accept in the tx_done cycle.
        tx_data = 8'h3C; tx_valid = 1'b1;
        run_frame("b2b_3c", 8'h3C, 1'b0, 0, 1, 8'hC3);
        run_frame("b2b_c3", 8'hC3, 1'b0, 0, 0, 8'h00);

        // Data and valid changes while busy are ignored.
        tx_data = 8'h81; tx_valid = 1'b1;
        run_frame("iso_81", 8'h81, 1'b0, 1, 0, 8'h00);

        // Reset during data bit 3 aborts the frame without tx_done.
        tx_data = 8'h96; tx_valid = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= 4 * CPB + 1; c++) begin
            @(negedge clk);
            if (c == 0) tx_valid = 1'b0;
        end
        check("mid state_d3", st, 5);
        check("mid ser_d3",   ser, 0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst ser",   ser, 1);
        check("mid_rst state", st, 0);
        check("mid_rst done",  done, 0);
        check("mid_rst ready", ready, 1);
        reset    = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (done !== 1'b0) done_cnt++;
        end
        check("mid_rst no_done", done_cnt, 0);
        tx_data = 8'h55; tx_valid = 1'b1;
        run_frame("after_rst_55", 8'h55, 1'b0, 0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
